mc_controller: RTL

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
// Multicycle MIPS-style control unit: Moore FSM sequencing fetch,
// decode, execute, memory and writeback steps for each opcode.
module mc_controller #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_JAL   = 6'b000011,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_SLTI  = 6'b001010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  output logic       IorD,
  output logic       memread,
  output logic       memwrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       regwrite,
  output logic       regdst,
  output logic       regsel,
  output logic       memtoreg,
  output logic       jal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQ    = 4'd8,
    S_JMP    = 4'd9,
    S_JALS   = 4'd10,
    S_IEXE   = 4'd11,
    S_IWB    = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next;

  logic       w_iord;
  logic       w_memread;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_pcwrite;
  logic       w_pcwritecond;
  logic [1:0] w_pcsrc;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_aluop;
  logic       w_regwrite;
  logic       w_regdst;
  logic       w_regsel;
  logic       w_memtoreg;
  logic       w_jal;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        // Unknown opcodes fall through to FETCH as a NOP
        case (opcode)
          OP_LW, OP_SW:     w_next = S_MEMADR;
          OP_RTYPE:         w_next = S_RTEXE;
          OP_BEQ:           w_next = S_BEQ;
          OP_J:             w_next = S_JMP;
          OP_JAL:           w_next = S_JALS;
          OP_ADDI, OP_SLTI: w_next = S_IEXE;
          default:          w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_RTEXE:  w_next = S_RTWB;
      S_IEXE:   w_next = S_IWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_iord        = 1'b0;
    w_memread     = 1'b0;
    w_memwrite    = 1'b0;
    w_irwrite     = 1'b0;
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    w_pcsrc       = 2'b00;
    w_alusrca     = 1'b0;
    w_alusrcb     = 2'b00;
    w_aluop       = 2'b00;
    w_regwrite    = 1'b0;
    w_regdst      = 1'b0;
    w_regsel      = 1'b0;
    w_memtoreg    = 1'b0;
    w_jal         = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        w_irwrite = 1'b1;
        w_alusrcb = 2'b01;
        w_pcwrite = 1'b1;
      end
      S_DECODE: w_alusrcb = 2'b11;
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_MEMRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
      end
      S_MEMWR: begin
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
      end
      S_RTEXE: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
      end
      S_RTWB: begin
        w_regwrite = 1'b1;
        w_regdst   = 1'b1;
      end
      S_BEQ: begin
        w_alusrca     = 1'b1;
        w_aluop       = 2'b01;
        w_pcwritecond = 1'b1;
        w_pcsrc       = 2'b10;
      end
      S_JMP: begin
        w_pcwrite = 1'b1;
        w_pcsrc   = 2'b01;
      end
      // Register file takes PC+4 on the same edge the PC takes the target
      S_JALS: begin
        w_pcwrite  = 1'b1;
        w_pcsrc    = 2'b01;
        w_regwrite = 1'b1;
        w_regsel   = 1'b1;
        w_jal      = 1'b1;
      end
      S_IEXE: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluop   = (opcode == OP_SLTI) ? 2'b11 : 2'b00;
      end
      S_IWB: w_regwrite = 1'b1;
      default: ;
    endcase
  end

  // Reset masks every strobe so no architectural write can occur
  assign IorD        = w_iord        & ~rst;
  assign memread     = w_memread     & ~rst;
  assign memwrite    = w_memwrite    & ~rst;
  assign IRWrite     = w_irwrite     & ~rst;
  assign PCWrite     = w_pcwrite     & ~rst;
  assign PCWriteCond = w_pcwritecond & ~rst;
  assign PCSrc       = rst ? 2'b00 : w_pcsrc;
  assign ALUSrcA     = w_alusrca     & ~rst;
  assign ALUSrcB     = rst ? 2'b00 : w_alusrcb;
  assign ALUOp       = rst ? 2'b00 : w_aluop;
  assign regwrite    = w_regwrite    & ~rst;
  assign regdst      = w_regdst      & ~rst;
  assign regsel      = w_regsel      & ~rst;
  assign memtoreg    = w_memtoreg    & ~rst;
  assign jal         = w_jal         & ~rst;
  assign state       = r_state;

endmodule
